// File: rtl/sq_pkg.sv
// Store queue package: configuration constants, pointer/entry types and age helpers.
// Loads and the squash logic measure age from a reference pointer, so wrap-around
// of the circular buffer never needs special casing.
package sq_pkg;

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned N_LD   = 2;
    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned PTR_W  = IDX_W + 1;
    localparam int unsigned BE_W   = DATA_W / 8;
    localparam int unsigned OFF_W  = $clog2(BE_W);

    typedef logic [PTR_W-1:0] sq_ptr_t;
    typedef logic [IDX_W-1:0] sq_idx_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              addr_rdy;
        logic [DATA_W-1:0] data;
        logic              data_rdy;
        logic [BE_W-1:0]   be;
        logic              valid;
        logic              committed;
    } sq_entry_t;

    // Distance of a pointer from a reference pointer (wrap bit included).
    function automatic sq_ptr_t age(sq_ptr_t ptr, sq_ptr_t head);
        return ptr - head;
    endfunction

    // Distance of a physical slot from a reference pointer.
    function automatic sq_ptr_t slot_age(sq_idx_t idx, sq_ptr_t head);
        sq_idx_t off;
        off = idx - head[IDX_W-1:0];
        return {1'b0, off};
    endfunction

endpackage

// File: rtl/store_queue_fwd_if.sv
// Store queue bus: dispatch, execute, retire, squash, load lookup and drain signals.
interface store_queue_fwd_if;
    import sq_pkg::*;

    logic                          disp_en;
    logic [ADDR_W-1:0]             disp_addr;
    logic                          disp_addr_rdy;
    logic [DATA_W-1:0]             disp_data;
    logic                          disp_data_rdy;
    logic [BE_W-1:0]               disp_be;
    sq_ptr_t                       disp_ptr;
    logic                          full;
    logic                          empty;
    logic                          ex_en;
    sq_ptr_t                       ex_ptr;
    logic                          ex_addr_en;
    logic [ADDR_W-1:0]             ex_addr;
    logic                          ex_data_en;
    logic [DATA_W-1:0]             ex_data;
    logic                          rt_en;
    logic                          squash_en;
    sq_ptr_t                       squash_tail;
    logic [N_LD-1:0]               ld_en;
    logic [N_LD-1:0][ADDR_W-1:0]   ld_addr;
    logic [N_LD-1:0][BE_W-1:0]     ld_be;
    sq_ptr_t [N_LD-1:0]            ld_pos;
    logic [N_LD-1:0]               ld_hit;
    logic [N_LD-1:0]               ld_stall;
    logic [N_LD-1:0][DATA_W-1:0]   ld_data;
    logic                          mem_valid;
    logic                          mem_ready;
    logic [ADDR_W-1:0]             mem_addr;
    logic [DATA_W-1:0]             mem_data;
    logic [BE_W-1:0]               mem_be;

    modport slave (
        input  disp_en, disp_addr, disp_addr_rdy, disp_data, disp_data_rdy, disp_be,
        output disp_ptr, full, empty,
        input  ex_en, ex_ptr, ex_addr_en, ex_addr, ex_data_en, ex_data,
        input  rt_en, squash_en, squash_tail,
        input  ld_en, ld_addr, ld_be, ld_pos,
        output ld_hit, ld_stall, ld_data,
        output mem_valid, mem_addr, mem_data, mem_be,
        input  mem_ready
    );

    modport master (
        output disp_en, disp_addr, disp_addr_rdy, disp_data, disp_data_rdy, disp_be,
        input  disp_ptr, full, empty,
        output ex_en, ex_ptr, ex_addr_en, ex_addr, ex_data_en, ex_data,
        output rt_en, squash_en, squash_tail,
        output ld_en, ld_addr, ld_be, ld_pos,
        input  ld_hit, ld_stall, ld_data,
        input  mem_valid, mem_addr, mem_data, mem_be,
        output mem_ready
    );

endinterface

// File: rtl/sq_fwd_sel.sv
// One load port's forwarding lookup: older-store mask, address/byte match,
// youngest-match select and stall decision. Purely combinational.
module sq_fwd_sel
    import sq_pkg::*;
(
    input  sq_entry_t [DEPTH-1:0] ents,
    input  sq_ptr_t               head,
    input  logic                  ld_en,
    input  logic [ADDR_W-1:0]     ld_addr,
    input  logic [BE_W-1:0]       ld_be,
    input  sq_ptr_t               ld_pos,
    output logic                  ld_hit,
    output logic                  ld_stall,
    output logic [DATA_W-1:0]     ld_data
);

    logic [DEPTH-1:0] older;
    logic [DEPTH-1:0] pending;
    logic [DEPTH-1:0] match;
    logic             found;
    logic             sel_blocked;
    sq_idx_t          sel;
    sq_idx_t          scan_idx;
    sq_ptr_t          span;
    logic             unused_in;

    assign span = age(ld_pos, head);

    // Classify each slot: older than the load, unresolved, or a byte-overlapping match.
    always_comb begin
        older   = '0;
        pending = '0;
        match   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            older[i]   = ents[i].valid && (slot_age(sq_idx_t'(i), head) < span);
            pending[i] = older[i] && !ents[i].addr_rdy;
            match[i]   = older[i] && ents[i].addr_rdy
                         && (ents[i].addr[ADDR_W-1:OFF_W] == ld_addr[ADDR_W-1:OFF_W])
                         && ((ents[i].be & ld_be) != '0);
        end
    end

    // Scan from oldest to youngest; the last match seen is the youngest older store.
    always_comb begin
        found    = 1'b0;
        sel      = '0;
        scan_idx = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            scan_idx = head[IDX_W-1:0] + sq_idx_t'(k);
            if (match[scan_idx]) begin
                found = 1'b1;
                sel   = scan_idx;
            end
        end
    end

    assign sel_blocked = found && (!ents[sel].data_rdy || ((ld_be & ~ents[sel].be) != '0));
    assign ld_stall    = ld_en && ((|pending) || sel_blocked);
    assign ld_hit      = ld_en && found && !ld_stall;
    assign ld_data     = ld_hit ? ents[sel].data : '0;

    // Offset bits and the commit flag play no part in forwarding.
    assign unused_in = ^{ents, ld_addr[OFF_W-1:0]};

endmodule

// File: rtl/store_queue_fwd.sv
// Circular store queue with per-port store-to-load forwarding, in-order retire,
// D-cache drain handshake and mispredict squash. Configuration lives in sq_pkg.
// Optional macro SQ_EX_BYPASS_EN: loads and the drain port also see the
// same-cycle execute update of the addressed entry.
module store_queue_fwd
    import sq_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    store_queue_fwd_if.slave sq
);

    sq_entry_t [DEPTH-1:0] ent_q, ent_d, ent_v;
    sq_ptr_t               head_q, head_d;
    sq_ptr_t               commit_q, commit_d;
    sq_ptr_t               tail_q, tail_d;
    logic                  full;
    logic                  mem_fire;
    logic                  unused_ptr;

    function automatic sq_entry_t apply_ex(sq_entry_t e, logic a_en, logic [ADDR_W-1:0] a,
                                           logic d_en, logic [DATA_W-1:0] d);
        sq_entry_t r;
        r = e;
        if (a_en) begin
            r.addr     = a;
            r.addr_rdy = 1'b1;
        end
        if (d_en) begin
            r.data     = d;
            r.data_rdy = 1'b1;
        end
        return r;
    endfunction

    // Full is derived from registered pointers, so a same-cycle drain never admits a dispatch.
    assign full         = (age(tail_q, head_q) == sq_ptr_t'(DEPTH));
    assign sq.full      = full;
    assign sq.empty     = (head_q == tail_q);
    assign sq.disp_ptr  = tail_q;
    assign sq.mem_valid = (head_q != commit_q);
    assign mem_fire     = sq.mem_valid && sq.mem_ready;
    assign sq.mem_addr  = ent_v[head_q[IDX_W-1:0]].addr;
    assign sq.mem_data  = ent_v[head_q[IDX_W-1:0]].data;
    assign sq.mem_be    = ent_v[head_q[IDX_W-1:0]].be;
    assign unused_ptr   = sq.ex_ptr[PTR_W-1];

`ifdef SQ_EX_BYPASS_EN
    // Lookup view with the in-flight execute update folded in.
    always_comb begin
        ent_v = ent_q;
        if (sq.ex_en) begin
            ent_v[sq.ex_ptr[IDX_W-1:0]] = apply_ex(ent_q[sq.ex_ptr[IDX_W-1:0]], sq.ex_addr_en,
                                                   sq.ex_addr, sq.ex_data_en, sq.ex_data);
        end
    end
`else
    assign ent_v = ent_q;
`endif

    // Next state: execute, dispatch, retire, drain, then squash (later steps win).
    always_comb begin
        ent_d    = ent_q;
        head_d   = head_q;
        commit_d = commit_q;
        tail_d   = tail_q;
        if (sq.ex_en) begin
            ent_d[sq.ex_ptr[IDX_W-1:0]] = apply_ex(ent_q[sq.ex_ptr[IDX_W-1:0]], sq.ex_addr_en,
                                                   sq.ex_addr, sq.ex_data_en, sq.ex_data);
        end
        if (sq.disp_en && !full && !sq.squash_en) begin
            ent_d[tail_q[IDX_W-1:0]].addr      = sq.disp_addr;
            ent_d[tail_q[IDX_W-1:0]].addr_rdy  = sq.disp_addr_rdy;
            ent_d[tail_q[IDX_W-1:0]].data      = sq.disp_data;
            ent_d[tail_q[IDX_W-1:0]].data_rdy  = sq.disp_data_rdy;
            ent_d[tail_q[IDX_W-1:0]].be        = sq.disp_be;
            ent_d[tail_q[IDX_W-1:0]].valid     = 1'b1;
            ent_d[tail_q[IDX_W-1:0]].committed = 1'b0;
            tail_d = tail_q + sq_ptr_t'(1);
        end
        if (sq.rt_en && (commit_q != tail_q)) begin
            ent_d[commit_q[IDX_W-1:0]].committed = 1'b1;
            commit_d = commit_q + sq_ptr_t'(1);
        end
        if (mem_fire) begin
            ent_d[head_q[IDX_W-1:0]] = '0;
            head_d = head_q + sq_ptr_t'(1);
        end
        if (sq.squash_en) begin
            tail_d = sq.squash_tail;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (slot_age(sq_idx_t'(i), sq.squash_tail) < age(tail_q, sq.squash_tail)) begin
                    ent_d[i] = '0;
                end
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            ent_q    <= '0;
            head_q   <= '0;
            commit_q <= '0;
            tail_q   <= '0;
        end else begin
            ent_q    <= ent_d;
            head_q   <= head_d;
            commit_q <= commit_d;
            tail_q   <= tail_d;
        end
    end

    logic [N_LD-1:0]             ld_hit_w;
    logic [N_LD-1:0]             ld_stall_w;
    logic [N_LD-1:0][DATA_W-1:0] ld_data_w;

    for (genvar p = 0; p < N_LD; p++) begin : g_ld
        sq_fwd_sel u_sel (
            .ents     (ent_v),
            .head     (head_q),
            .ld_en    (sq.ld_en[p]),
            .ld_addr  (sq.ld_addr[p]),
            .ld_be    (sq.ld_be[p]),
            .ld_pos   (sq.ld_pos[p]),
            .ld_hit   (ld_hit_w[p]),
            .ld_stall (ld_stall_w[p]),
            .ld_data  (ld_data_w[p])
        );
    end

    assign sq.ld_hit   = ld_hit_w;
    assign sq.ld_stall = ld_stall_w;
    assign sq.ld_data  = ld_data_w;

    // Squash may only roll the tail back to a point between commit and tail.
    a_squash_range: assert property (@(posedge clock) disable iff (reset)
        sq.squash_en |-> (age(sq.squash_tail, commit_q) <= age(tail_q, commit_q)));

endmodule

// File: tb/tb_store_queue_fwd.sv
// Directed bench for store_queue_fwd: fill/full, forwarding, stalls, squash, drain, wrap.
module tb_store_queue_fwd;
    import sq_pkg::*;

`ifdef SQ_EX_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    store_queue_fwd_if sq_if ();

    store_queue_fwd dut (
        .clock (clock),
        .reset (reset),
        .sq    (sq_if)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic disp(input logic [31:0] a, input logic ar, input logic [63:0] d,
                        input logic dr, input logic [7:0] be);
        sq_if.disp_en       = 1'b1;
        sq_if.disp_addr     = a;
        sq_if.disp_addr_rdy = ar;
        sq_if.disp_data     = d;
        sq_if.disp_data_rdy = dr;
        sq_if.disp_be       = be;
        tick();
        sq_if.disp_en = 1'b0;
    endtask

    task automatic load(input int p, input logic [31:0] a, input logic [7:0] be,
                        input logic [3:0] pos);
        sq_if.ld_en[p]   = 1'b1;
        sq_if.ld_addr[p] = a;
        sq_if.ld_be[p]   = be;
        sq_if.ld_pos[p]  = pos;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sq_if.ld_en = '0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        sq_if.disp_en = 0; sq_if.disp_addr = 0; sq_if.disp_addr_rdy = 0;
        sq_if.disp_data = 0; sq_if.disp_data_rdy = 0; sq_if.disp_be = 0;
        sq_if.ex_en = 0; sq_if.ex_ptr = 0; sq_if.ex_addr_en = 0; sq_if.ex_addr = 0;
        sq_if.ex_data_en = 0; sq_if.ex_data = 0; sq_if.rt_en = 0;
        sq_if.squash_en = 0; sq_if.squash_tail = 0; sq_if.ld_en = 0;
        sq_if.ld_addr = 0; sq_if.ld_be = 0; sq_if.ld_pos = 0; sq_if.mem_ready = 0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_empty", sq_if.empty, 1);
        check("rst_full", sq_if.full, 0);
        check("rst_disp_ptr", sq_if.disp_ptr, 0);
        check("rst_mem_valid", sq_if.mem_valid, 0);
        check("rst_mem_addr", sq_if.mem_addr, 0);
        check("rst_ld_hit", sq_if.ld_hit, 0);
        check("rst_ld_stall", sq_if.ld_stall, 0);

        // Fill to full; 9th dispatch ignored
        for (int i = 0; i < 8; i++) begin
            disp(32'h1000 + 32'(8 * i), 1'b1, 64'(i), 1'b1, 8'hFF);
            if (i == 6) check("full_at_7", sq_if.full, 0);
        end
        check("full_at_8", sq_if.full, 1);
        check("ptr_at_8", sq_if.disp_ptr, 4'b1000);
        check("not_empty", sq_if.empty, 0);
        disp(32'h9999, 1'b1, 64'h9, 1'b1, 8'hFF);
        check("ptr_9th_ignored", sq_if.disp_ptr, 4'b1000);
        check("full_9th", sq_if.full, 1);

        // Retire one, then drain and dispatch together while full
        sq_if.rt_en = 1'b1; tick(); sq_if.rt_en = 1'b0;
        check("drain_valid", sq_if.mem_valid, 1);
        check("drain_addr", sq_if.mem_addr, 32'h1000);
        sq_if.mem_ready = 1'b1; sq_if.disp_en = 1'b1; tick();
        sq_if.mem_ready = 1'b0; sq_if.disp_en = 1'b0;
        check("full_disp_rejected", sq_if.disp_ptr, 4'b1000);
        check("full_after_drain", sq_if.full, 0);
        check("drain_valid_off", sq_if.mem_valid, 0);
        check("head_addr_next", sq_if.mem_addr, 32'h1008);

        // Basic forward and no-older-store lookup
        do_reset();
        disp(32'h100, 1'b1, 64'hDEAD, 1'b1, 8'hFF);
        load(0, 32'h100, 8'h0F, 4'd1);
        load(1, 32'h100, 8'hFF, 4'd0);
        check("fwd_hit", sq_if.ld_hit[0], 1);
        check("fwd_data", sq_if.ld_data[0], 64'hDEAD);
        check("fwd_stall", sq_if.ld_stall[0], 0);
        check("noolder_hit", sq_if.ld_hit[1], 0);
        check("noolder_stall", sq_if.ld_stall[1], 0);
        check("noolder_data", sq_if.ld_data[1], 0);

        // Youngest older store wins
        disp(32'h100, 1'b1, 64'h1, 1'b1, 8'hFF);
        disp(32'h100, 1'b1, 64'h2, 1'b1, 8'hFF);
        load(0, 32'h100, 8'hFF, 4'd3);
        load(1, 32'h100, 8'hFF, 4'd2);
        check("young_after_both", sq_if.ld_data[0], 64'h2);
        check("young_between", sq_if.ld_data[1], 64'h1);
        load(1, 32'h104, 8'hF0, 4'd3);
        check("same_word_hit", sq_if.ld_hit[1], 1);
        check("same_word_data", sq_if.ld_data[1], 64'h2);

        // Unresolved older address stalls until execute resolves it
        disp(32'h400, 1'b0, 64'h44, 1'b1, 8'hFF);
        load(0, 32'h100, 8'h0F, 4'd4);
        check("addr_unrdy_stall", sq_if.ld_stall[0], 1);
        check("addr_unrdy_hit", sq_if.ld_hit[0], 0);
        check("addr_unrdy_data", sq_if.ld_data[0], 0);
        sq_if.ex_en = 1'b1; sq_if.ex_ptr = 4'd3; sq_if.ex_addr_en = 1'b1; sq_if.ex_addr = 32'h400;
        #1;
        check("ex_same_cycle_stall", sq_if.ld_stall[0], BYP ? 64'd0 : 64'd1);
        tick();
        sq_if.ex_en = 1'b0; sq_if.ex_addr_en = 1'b0;
        #1;
        check("ex_resolved_hit", sq_if.ld_hit[0], 1);
        check("ex_resolved_data", sq_if.ld_data[0], 64'h2);

        // Partial byte coverage stalls
        disp(32'h500, 1'b1, 64'hAB, 1'b1, 8'h0F);
        load(1, 32'h500, 8'hFF, 4'd5);
        check("be_cover_stall", sq_if.ld_stall[1], 1);
        check("be_cover_hit", sq_if.ld_hit[1], 0);

        // Match without data stalls until data arrives
        disp(32'h600, 1'b1, 64'h0, 1'b0, 8'hFF);
        load(1, 32'h600, 8'hFF, 4'd6);
        check("data_unrdy_stall", sq_if.ld_stall[1], 1);
        sq_if.ex_en = 1'b1; sq_if.ex_ptr = 4'd5; sq_if.ex_data_en = 1'b1; sq_if.ex_data = 64'h66;
        tick();
        sq_if.ex_en = 1'b0; sq_if.ex_data_en = 1'b0;
        #1;
        check("data_rdy_hit", sq_if.ld_hit[1], 1);
        check("data_rdy_data", sq_if.ld_data[1], 64'h66);

        // Squash: 4 stores, retire 2, roll tail back to 3 (overrides a dispatch)
        do_reset();
        for (int i = 0; i < 4; i++) disp(32'h800 + 32'(8 * i), 1'b1, 64'(i), 1'b1, 8'hFF);
        sq_if.rt_en = 1'b1; tick(); tick(); sq_if.rt_en = 1'b0;
        sq_if.squash_en = 1'b1; sq_if.squash_tail = 4'd3; sq_if.disp_en = 1'b1; tick();
        sq_if.squash_en = 1'b0; sq_if.disp_en = 1'b0;
        check("squash_tail", sq_if.disp_ptr, 4'd3);
        check("squash_not_empty", sq_if.empty, 0);
        sq_if.mem_ready = 1'b1;
        #1;
        check("pop1_valid", sq_if.mem_valid, 1);
        check("pop1_addr", sq_if.mem_addr, 32'h800);
        tick();
        check("pop2_valid", sq_if.mem_valid, 1);
        check("pop2_addr", sq_if.mem_addr, 32'h808);
        tick();
        check("pop_done", sq_if.mem_valid, 0);
        tick();
        check("pop_stays_done", sq_if.mem_valid, 0);
        sq_if.rt_en = 1'b1; tick(); sq_if.rt_en = 1'b0;
        check("pop3_addr", sq_if.mem_addr, 32'h810);
        check("pop3_valid", sq_if.mem_valid, 1);
        tick();
        check("squashed_gone_empty", sq_if.empty, 1);
        sq_if.rt_en = 1'b1; tick(); sq_if.rt_en = 1'b0;
        check("retire_empty_ignored", sq_if.mem_valid, 0);
        sq_if.mem_ready = 1'b0;

        // Wrap-around: cycle 20 stores, then forward across slot 7 -> 0
        do_reset();
        for (int i = 0; i < 20; i++) begin
            disp(32'h2000 + 32'(8 * i), 1'b1, 64'(i), 1'b1, 8'hFF);
            sq_if.rt_en = 1'b1; tick(); sq_if.rt_en = 1'b0;
            sq_if.mem_ready = 1'b1; tick(); sq_if.mem_ready = 1'b0;
        end
        check("cycled_empty", sq_if.empty, 1);
        check("cycled_ptr", sq_if.disp_ptr, 4'd4);
        disp(32'h200, 1'b1, 64'h11, 1'b1, 8'hFF);
        disp(32'h208, 1'b1, 64'h55, 1'b1, 8'hFF);
        disp(32'h300, 1'b1, 64'h66, 1'b1, 8'hFF);
        disp(32'h200, 1'b1, 64'h77, 1'b1, 8'hFF);
        disp(32'h200, 1'b1, 64'h88, 1'b1, 8'hFF);
        check("wrap_ptr", sq_if.disp_ptr, 4'b1001);
        load(0, 32'h200, 8'hFF, 4'b1001);
        load(1, 32'h200, 8'hFF, 4'b1000);
        check("wrap_youngest", sq_if.ld_data[0], 64'h88);
        check("wrap_youngest_hit", sq_if.ld_hit[0], 1);
        check("wrap_before_zero", sq_if.ld_data[1], 64'h77);
        load(0, 32'h200, 8'hFF, 4'd7);
        check("wrap_oldest", sq_if.ld_data[0], 64'h11);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/store_queue_fwd.md
Name: store_queue_fwd

Overview:
Parametrised circular store queue for the R10K-style LSQ. It holds dispatched stores until their address and data resolve, then until retire commits them, then until the D-cache drain handshake accepts them. It serves N_LD load ports with byte-masked store-to-load forwarding from the youngest older matching store, and supports branch-mispredict squash.

Parameters:
DEPTH, 8, number of entries; power of two, >=2
ADDR_W, 32, byte address width
DATA_W, 64, data width; DATA_W/8 byte-enable bits
N_LD, 2, number of independent load forwarding ports
Derived: IDX_W=$clog2(DEPTH); PTR_W=IDX_W+1 (MSB is the wrap bit); BE_W=DATA_W/8

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high
disp_en  in  1  dispatch one store
disp_addr / disp_addr_rdy  in  ADDR_W / 1  address and its ready flag
disp_data / disp_data_rdy  in  DATA_W / 1  data and its ready flag
disp_be  in  BE_W  byte enables
disp_ptr  out  PTR_W  pointer assigned to the dispatching store (current tail)
full / empty  out  1 / 1  occupancy flags
ex_en / ex_ptr  in  1 / PTR_W  execute update and target entry
ex_addr_en / ex_addr  in  1 / ADDR_W  resolved address
ex_data_en / ex_data  in  1 / DATA_W  resolved data
rt_en  in  1  commit the oldest uncommitted store
squash_en / squash_tail  in  1 / PTR_W  roll tail back to squash_tail
ld_en  in  N_LD  load lookup valid, per port
ld_addr  in  N_LD x ADDR_W  load address
ld_be  in  N_LD x BE_W  load byte enables
ld_pos  in  N_LD x PTR_W  SQ tail captured when the load dispatched
ld_hit / ld_stall  out  N_LD / N_LD  forward valid / load must wait
ld_data  out  N_LD x DATA_W  forwarded data
mem_valid / mem_ready  out / in  1 / 1  drain handshake
mem_addr / mem_data / mem_be  out  ADDR_W / DATA_W / BE_W  head store

Behaviour:
- Pointers head, commit and tail are PTR_W wide. Order is head <= commit <= tail. Count = tail - head (mod 2^PTR_W).
- full = (count == DEPTH); all DEPTH slots are usable. empty = (head == tail).
- Reset: head, commit and tail = 0; all valid/ready/committed bits = 0; all outputs 0; empty = 1.
- Dispatch: when disp_en & !full, write the entry at tail[IDX_W-1:0] and increment tail. disp_en while full is ignored (no state change). disp_ptr always equals the registered tail.
- Execute: on ex_en, set addr/addr_rdy if ex_addr_en, and data/data_rdy if ex_data_en. Updates are visible to loads the next cycle.
- Retire: rt_en with commit != tail sets committed[commit] and increments commit. rt_en with commit == tail is ignored.
- Drain: mem_valid = (head != commit). It presents the head entry. On mem_valid & mem_ready, clear the head entry and increment head.
- Squash: on squash_en, tail <= squash_tail and entries in [squash_tail, old tail) are cleared. Squash overrides same-cycle dispatch; retire, drain and execute proceed normally. squash_tail outside [commit, tail] is illegal (assert).
- Load port p, purely combinational from registered state:
  - Older set = valid entries in [head, ld_pos[p]).
  - Match = older & addr_rdy & (addr[ADDR_W-1:log2 BE_W] == ld_addr word) & (be & ld_be) != 0.
  - ld_stall = ld_en & (any older entry with !addr_rdy, OR youngest match lacks data_rdy, OR youngest match's be does not cover ld_be).
  - ld_hit = ld_en & some match & !ld_stall. ld_data = that entry's data (0 when !ld_hit).
  - Youngest is measured relative to head, so wrap-around is handled by age = ptr - head.
- Simultaneous dispatch and drain when full: drain frees a slot, but full is registered, so dispatch is still rejected that cycle.

Optional Feature:
SQ_EX_BYPASS_EN: when defined, load lookups and mem_* outputs see the same-cycle ex_* update of the addressed entry (zero-cycle bypass). When undefined, they see only registered state (one-cycle visibility delay). All other behaviour is identical.

Decomposition:
- Package sq_pkg: sq_ptr_t (PTR_W), sq_entry_t struct {addr, addr_rdy, data, data_rdy, be, valid, committed}, and an age function ptr-head.
- Sub-module sq_fwd_sel: one load port's older-mask, match, youngest priority select and stall logic. It is instantiated N_LD times.

Test Plan:
- Reset, then dispatch 8 stores with no drain -> full=1 after the 8th; a 9th disp_en leaves tail=8 (wrapped pointer 4'b1000); empty=0.
- Store A=0x100, data=0xDEAD, be=0xFF; load 0x100, be=0x0F, ld_pos after store -> ld_hit=1, ld_data=0xDEAD, ld_stall=0.
- Two older stores to 0x100 with data 1 then 2; load after both -> ld_data=2. Load with ld_pos between them -> ld_data=1.
- Older store with addr_rdy=0 -> ld_stall=1. Store be=0x0F with load be=0xFF -> ld_stall=1, ld_hit=0.
- Dispatch 4 stores, rt_en x2, squash_tail=commit+1 -> tail=3, occupancy 3. Drain with mem_ready=1 pops exactly 2 stores, then mem_valid=0.
- Wrap-around: cycle 20 stores through dispatch/commit/drain, then forward across the index-7→0 boundary -> the youngest older store is selected correctly.
